lcd_msg_controller: RTL

LCD_MSG_CONTROLLER -- requirements
Module: lcd_msg_controller

---
 rtl/lcd_msg_controller.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_msg_controller.sv
// lcd_msg_controller: HD44780 (8-bit, write-only) message controller.
// A byte engine sequences SETUP -> EN strobe -> settle wait for every byte.
// A main FSM runs the power-up init, then announces "PLAYER n WINS" for each
// rising edge seen on the per-player win inputs, lowest index first.
// Optional feature macro: LCD_SCORE_EN adds per-player decimal win counters
// and a second line "SCORE d" after each announcement.
module lcd_msg_controller #(
    parameter int NUM_PLAYERS    = 2,
    parameter int EN_HIGH_CYC    = 4,
    parameter int CMD_WAIT_CYC   = 8,
    parameter int CLEAR_WAIT_CYC = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] win,
    output logic                   LCD_RS,
    output logic                   LCD_RW,
    output logic                   LCD_EN,
    output logic [7:0]             LCD_DATA,
    output logic                   rdy_command,
    output logic                   rdy,
    output logic [3:0]             state
);

    localparam int PW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int CMAX = (EN_HIGH_CYC > CMD_WAIT_CYC) ?
                          ((EN_HIGH_CYC > CLEAR_WAIT_CYC) ? EN_HIGH_CYC : CLEAR_WAIT_CYC) :
                          ((CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        E_IDLE   = 2'd0,
        E_SETUP  = 2'd1,
        E_STROBE = 2'd2,
        E_WAIT   = 2'd3
    } eng_t;

    typedef enum logic [3:0] {
        S_INIT  = 4'd1,
        S_IDLE  = 4'd2,
        S_CLEAR = 4'd3,
        S_HOME  = 4'd4,
        S_MSG   = 4'd5
`ifdef LCD_SCORE_EN
        ,
        S_LINE2 = 4'd6,
        S_SCORE = 4'd7
`endif
    } state_t;

    // byte engine registers
    eng_t          eng_q;
    logic [CW-1:0] ecnt_q;
    logic          en_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          rdyc_q;

    // main FSM registers
    state_t                 state_q;
    logic [3:0]             idx_q;
    logic [PW-1:0]          player_q;
    logic [NUM_PLAYERS-1:0] pend_q;
    logic [NUM_PLAYERS-1:0] win_q;
    logic                   iss_q;
    logic                   iss_rs_q;
    logic [7:0]             iss_byte_q;

`ifdef LCD_SCORE_EN
    logic [NUM_PLAYERS-1:0][3:0] score_q;
`endif

    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] sel_oh;
    logic [PW-1:0]          sel_c;
    logic [3:0]             len_c;
    logic [7:0]             byte_c;
    logic                   rs_c;
    state_t                 nxt_c;

    assign rise        = win & ~win_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = 1'b0;
    assign LCD_EN      = en_q;
    assign LCD_DATA    = data_q;
    assign rdy_command = rdyc_q;
    assign state       = state_q;
    assign rdy         = (state_q == S_IDLE) && (pend_q == '0);

    // Lowest-index pending player wins arbitration.
    always_comb begin
        sel_c  = '0;
        sel_oh = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_c     = PW'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    // Byte table per state: how many bytes, which byte at idx_q, and where to go after.
    always_comb begin
        len_c  = 4'd0;
        byte_c = 8'h00;
        rs_c   = 1'b0;
        nxt_c  = S_IDLE;
        case (state_q)
            S_INIT: begin
                len_c = 4'd4;
                case (idx_q)
                    4'd0:    byte_c = 8'h38;
                    4'd1:    byte_c = 8'h0C;
                    4'd2:    byte_c = 8'h06;
                    default: byte_c = 8'h01;
                endcase
            end
            S_CLEAR: begin
                len_c  = 4'd1;
                byte_c = 8'h01;
                nxt_c  = S_HOME;
            end
            S_HOME: begin
                len_c  = 4'd1;
                byte_c = 8'h80;
                nxt_c  = S_MSG;
            end
            S_MSG: begin
                len_c = 4'd13;
                rs_c  = 1'b1;
`ifdef LCD_SCORE_EN
                nxt_c = S_LINE2;
`endif
                case (idx_q)
                    4'd0:    byte_c = 8'h50;   // P
                    4'd1:    byte_c = 8'h4C;   // L
                    4'd2:    byte_c = 8'h41;   // A
                    4'd3:    byte_c = 8'h59;   // Y
                    4'd4:    byte_c = 8'h45;   // E
                    4'd5:    byte_c = 8'h52;   // R
                    4'd6:    byte_c = 8'h20;
                    4'd7:    byte_c = 8'h31 + 8'(player_q);
                    4'd8:    byte_c = 8'h20;
                    4'd9:    byte_c = 8'h57;   // W
                    4'd10:   byte_c = 8'h49;   // I
                    4'd11:   byte_c = 8'h4E;   // N
                    default: byte_c = 8'h53;   // S
                endcase
            end
`ifdef LCD_SCORE_EN
            S_LINE2: begin
                len_c  = 4'd1;
                byte_c = 8'hC0;
                nxt_c  = S_SCORE;
            end
            S_SCORE: begin
                len_c = 4'd7;
                rs_c  = 1'b1;
                case (idx_q)
                    4'd0:    byte_c = 8'h53;   // S
                    4'd1:    byte_c = 8'h43;   // C
                    4'd2:    byte_c = 8'h4F;   // O
                    4'd3:    byte_c = 8'h52;   // R
                    4'd4:    byte_c = 8'h45;   // E
                    4'd5:    byte_c = 8'h20;
                    default: byte_c = 8'h30 + {4'h0, score_q[player_q]};
                endcase
            end
`endif
            default: ;
        endcase
    end

    // Byte engine: setup cycle, EN strobe, then settle wait (long after clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_q  <= E_IDLE;
            ecnt_q <= '0;
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            rdyc_q <= 1'b0;
        end else begin
            case (eng_q)
                E_IDLE: begin
                    rdyc_q <= 1'b1;
                    if (iss_q) begin
                        eng_q  <= E_SETUP;
                        rs_q   <= iss_rs_q;
                        data_q <= iss_byte_q;
                        rdyc_q <= 1'b0;
                    end
                end
                E_SETUP: begin
                    eng_q  <= E_STROBE;
                    en_q   <= 1'b1;
                    ecnt_q <= CW'(EN_HIGH_CYC - 1);
                end
                E_STROBE: begin
                    if (ecnt_q == '0) begin
                        eng_q  <= E_WAIT;
                        en_q   <= 1'b0;
                        ecnt_q <= (data_q == 8'h01 && !rs_q) ? CW'(CLEAR_WAIT_CYC - 1)
                                                              : CW'(CMD_WAIT_CYC - 1);
                    end else begin
                        ecnt_q <= ecnt_q - 1'b1;
                    end
                end
                default: begin
                    if (ecnt_q == '0) begin
                        eng_q  <= E_IDLE;
                        rdyc_q <= 1'b1;
                    end else begin
                        ecnt_q <= ecnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Main FSM: issue one byte per engine-ready, move on once the last byte has settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            idx_q      <= 4'd0;
            player_q   <= '0;
            pend_q     <= '0;
            win_q      <= '0;
            iss_q      <= 1'b0;
            iss_rs_q   <= 1'b0;
            iss_byte_q <= 8'h00;
        end else begin
            win_q  <= win;
            iss_q  <= 1'b0;
            pend_q <= pend_q | rise;
            if (state_q == S_IDLE) begin
                if (|pend_q) begin
                    state_q  <= S_CLEAR;
                    player_q <= sel_c;
                    idx_q    <= 4'd0;
                    pend_q   <= (pend_q & ~sel_oh) | rise;
                end
            end else if (rdyc_q && !iss_q) begin
                if (idx_q < len_c) begin
                    iss_q      <= 1'b1;
                    iss_rs_q   <= rs_c;
                    iss_byte_q <= byte_c;
                    idx_q      <= idx_q + 4'd1;
                end else begin
                    idx_q   <= 4'd0;
                    state_q <= nxt_c;
                end
            end
        end
    end

`ifdef LCD_SCORE_EN
    // Decimal win counters, bumped when a player's announcement starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else if (state_q == S_IDLE && (|pend_q)) begin
            score_q[sel_c] <= (score_q[sel_c] == 4'd9) ? 4'd0 : score_q[sel_c] + 4'd1;
        end
    end
`endif

endmodule
